// File: rtl/wb_arbiter_if.sv
// Writeback port bundle: two writeback request sources in, one register-file write port and
// a per-register pending-write vector out.
interface wb_arbiter_if;
  logic        alu_valid;
  logic [4:0]  alu_rd;
  logic [31:0] alu_data;
  logic        alu_ready;
  logic        ld_valid;
  logic [4:0]  ld_rd;
  logic [31:0] ld_data;
  logic        ld_ready;
  logic        RegW;
  logic [4:0]  A3;
  logic [31:0] Result;
  logic [31:0] busy;

  modport master (
    output alu_valid, alu_rd, alu_data, ld_valid, ld_rd, ld_data,
    input  alu_ready, ld_ready, RegW, A3, Result, busy
  );

  modport slave (
    input  alu_valid, alu_rd, alu_data, ld_valid, ld_rd, ld_data,
    output alu_ready, ld_ready, RegW, A3, Result, busy
  );
endinterface

// File: rtl/wb_arbiter.sv
// Writeback arbiter: one FIFO per source (ALU, load), round-robin grant onto a single
// registered register-file write port, plus a pending-write scoreboard for decode stalls.
module wb_arbiter #(
  parameter int DEPTH = 2
) (
  input  logic         clk,
  input  logic         reset,
  wb_arbiter_if.slave  bus
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

  typedef enum logic {SRC_ALU = 1'b0, SRC_LD = 1'b1} src_e;

  logic [4:0]       q_rd   [2][DEPTH];
  logic [31:0]      q_data [2][DEPTH];
  logic [PTR_W-1:0] wptr   [2];
  logic [PTR_W-1:0] rptr   [2];
  logic [CNT_W-1:0] count  [2];
  src_e             last_grant;

  logic [1:0]       in_valid;
  logic [4:0]       in_rd   [2];
  logic [31:0]      in_data [2];
  logic [1:0]       ready;
  logic [1:0]       push;
  logic [1:0]       pop;
  logic [1:0]       nonempty;

  logic             gnt_valid;
  src_e             gnt_src;
  logic [4:0]       head_rd;
  logic [31:0]      head_data;

  logic             reg_w;
  logic [4:0]       a3;
  logic [31:0]      result;
  logic [31:0]      busy_c;
  logic [PTR_W-1:0] offset;

  assign in_valid   = {bus.ld_valid, bus.alu_valid};
  assign in_rd[0]   = bus.alu_rd;
  assign in_rd[1]   = bus.ld_rd;
  assign in_data[0] = bus.alu_data;
  assign in_data[1] = bus.ld_data;

  always_comb begin
    for (int s = 0; s < 2; s++) begin
      ready[s]    = reset && (count[s] < FULL);
      push[s]     = in_valid[s] && ready[s];
      nonempty[s] = (count[s] != '0);
    end
  end

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    gnt_valid = |nonempty;
    gnt_src   = SRC_ALU;
    pop       = '0;
    if (&nonempty)
      gnt_src = (last_grant == SRC_LD) ? SRC_ALU : SRC_LD;
    else if (nonempty[SRC_LD])
      gnt_src = SRC_LD;
    if (gnt_valid)
      pop[gnt_src] = 1'b1;
    head_rd   = q_rd[gnt_src][rptr[gnt_src]];
    head_data = q_data[gnt_src][rptr[gnt_src]];
  end

  // NOTE: the FIFO storage has no reset; occupancy alone decides which entries are live.
  always_ff @(posedge clk) begin
    for (int s = 0; s < 2; s++) begin
      if (push[s]) begin
        q_rd[s][wptr[s]]   <= in_rd[s];
        q_data[s][wptr[s]] <= in_data[s];
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int s = 0; s < 2; s++) begin
        wptr[s]  <= '0;
        rptr[s]  <= '0;
        count[s] <= '0;
      end
      last_grant <= SRC_LD;
      reg_w      <= 1'b0;
      a3         <= '0;
      result     <= '0;
    end else begin
      for (int s = 0; s < 2; s++) begin
        if (push[s]) wptr[s] <= wptr[s] + 1'b1;
        if (pop[s])  rptr[s] <= rptr[s] + 1'b1;
        case ({push[s], pop[s]})
          2'b10:   count[s] <= count[s] + 1'b1;
          2'b01:   count[s] <= count[s] - 1'b1;
          default: ;
        endcase
      end
      if (gnt_valid)
        last_grant <= gnt_src;
      // An rd=0 entry is consumed by its grant but never written.
      reg_w <= gnt_valid && (head_rd != '0);
      if (gnt_valid && (head_rd != '0)) begin
        a3     <= head_rd;
        result <= head_data;
      end
    end
  end

  always_comb begin
    busy_c = '0;
    offset = '0;
    for (int s = 0; s < 2; s++) begin
      for (int i = 0; i < DEPTH; i++) begin
        offset = PTR_W'(i) - rptr[s];
        if ({1'b0, offset} < count[s])
          busy_c[q_rd[s][i]] = 1'b1;
      end
    end
    if (reg_w)
      busy_c[a3] = 1'b1;
    busy_c[0] = 1'b0;
  end

  assign bus.alu_ready = ready[SRC_ALU];
  assign bus.ld_ready  = ready[SRC_LD];
  assign bus.RegW      = reg_w;
  assign bus.A3        = a3;
  assign bus.Result    = result;
  assign bus.busy      = busy_c;

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed bench for wb_arbiter: a per-cycle vector table for single-cycle behaviour plus a
// streaming sequence for round-robin alternation, back-pressure and throughput.
module tb_wb_arbiter;

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  wb_arbiter_if bus ();

  wb_arbiter #(.DEPTH(2)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, required finish before 200000");
    $fatal(1);
  end

  typedef struct {
    logic        rst;
    logic        av;
    logic [4:0]  ard;
    logic [31:0] adat;
    logic        lv;
    logic [4:0]  lrd;
    logic [31:0] ldat;
    logic        e_ar;
    logic        e_lr;
    logic        e_regw;
    logic [4:0]  e_a3;
    logic [31:0] e_res;
    logic [31:0] e_busy;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input int idx, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s[%0d]: got 0x%08h expected 0x%08h", name, idx, act, exp);
    end
  endtask

  task automatic add(input logic rst, input logic av, input logic [4:0] ard,
                     input logic [31:0] adat, input logic lv, input logic [4:0] lrd,
                     input logic [31:0] ldat, input logic e_ar, input logic e_lr,
                     input logic e_regw, input logic [4:0] e_a3, input logic [31:0] e_res,
                     input logic [31:0] e_busy);
    vecs.push_back('{rst, av, ard, adat, lv, lrd, ldat, e_ar, e_lr, e_regw, e_a3, e_res, e_busy});
  endtask

  int          ai, li, nw, first_cyc, last_cyc;
  logic        alu_stall, ld_stall;
  logic [4:0]  got_rd   [8];
  logic [31:0] got_data [8];

  initial begin
    checks = 0;
    errors = 0;
    reset  = 1'b0;
    bus.alu_valid = 1'b0; bus.alu_rd = '0; bus.alu_data = '0;
    bus.ld_valid  = 1'b0; bus.ld_rd  = '0; bus.ld_data  = '0;

    //   rst av ard adat          lv lrd ldat          ar lr rw a3 result        busy
    add(0, 0, 0,  32'h0,         0, 0,  32'h0,         0, 0, 0, 0, 32'h0,        32'h0);
    // single write, 2-cycle latency, one-cycle RegW pulse
    add(1, 1, 5,  32'hDEADBEEF,  0, 0,  32'h0,         1, 1, 0, 0, 32'h0,        32'h0);
    add(1, 0, 0,  32'h0,         0, 0,  32'h0,         1, 1, 0, 0, 32'h0,        32'h20);
    add(1, 0, 0,  32'h0,         0, 0,  32'h0,         1, 1, 1, 5, 32'hDEADBEEF, 32'h20);
    add(1, 0, 0,  32'h0,         0, 0,  32'h0,         1, 1, 0, 5, 32'hDEADBEEF, 32'h0);
    // rd=0 discard still moves the last-grant flag; the next tie goes to LD
    add(1, 0, 0,  32'h0,         1, 9,  32'h99990009,  1, 1, 0, 5, 32'hDEADBEEF, 32'h0);
    add(1, 1, 0,  32'h12345678,  0, 0,  32'h0,         1, 1, 0, 5, 32'hDEADBEEF, 32'h200);
    add(1, 0, 0,  32'h0,         0, 0,  32'h0,         1, 1, 1, 9, 32'h99990009, 32'h200);
    add(1, 1, 7,  32'h77770007,  1, 8,  32'h88880008,  1, 1, 0, 9, 32'h99990009, 32'h0);
    add(1, 0, 0,  32'h0,         0, 0,  32'h0,         1, 1, 0, 9, 32'h99990009, 32'h180);
    add(1, 0, 0,  32'h0,         0, 0,  32'h0,         1, 1, 1, 8, 32'h88880008, 32'h180);
    add(1, 0, 0,  32'h0,         0, 0,  32'h0,         1, 1, 1, 7, 32'h77770007, 32'h80);
    add(1, 0, 0,  32'h0,         0, 0,  32'h0,         1, 1, 0, 7, 32'h77770007, 32'h0);
    // push and pop together at occupancy 1
    add(1, 1, 3,  32'h33,        0, 0,  32'h0,         1, 1, 0, 7, 32'h77770007, 32'h0);
    add(1, 1, 4,  32'h44,        0, 0,  32'h0,         1, 1, 0, 7, 32'h77770007, 32'h8);
    add(1, 0, 0,  32'h0,         0, 0,  32'h0,         1, 1, 1, 3, 32'h33,       32'h18);
    add(1, 0, 0,  32'h0,         0, 0,  32'h0,         1, 1, 1, 4, 32'h44,       32'h10);
    add(1, 0, 0,  32'h0,         0, 0,  32'h0,         1, 1, 0, 4, 32'h44,       32'h0);
    // reset with two queued entries and one write in the output register
    add(1, 1, 20, 32'h14,        1, 21, 32'h15,        1, 1, 0, 4, 32'h44,       32'h0);
    add(1, 1, 22, 32'h16,        0, 0,  32'h0,         1, 1, 0, 4, 32'h44,       32'h00300000);
    add(0, 0, 0,  32'h0,         0, 0,  32'h0,         0, 0, 1, 21, 32'h15,      32'h00700000);
    add(1, 0, 0,  32'h0,         0, 0,  32'h0,         1, 1, 0, 0, 32'h0,        32'h0);
    add(1, 0, 0,  32'h0,         0, 0,  32'h0,         1, 1, 0, 0, 32'h0,        32'h0);
    // fill the LD FIFO behind an ALU write, refuse a third LD entry, drain in order
    add(1, 1, 1,  32'hA1,        1, 11, 32'hB1,        1, 1, 0, 0, 32'h0,        32'h0);
    add(1, 1, 2,  32'hA2,        1, 12, 32'hB2,        1, 1, 0, 0, 32'h0,        32'h802);
    add(1, 0, 0,  32'h0,         1, 13, 32'hB3,        1, 0, 1, 1, 32'hA1,       32'h1806);
    add(1, 0, 0,  32'h0,         0, 0,  32'h0,         1, 1, 1, 11, 32'hB1,      32'h1804);
    add(1, 0, 0,  32'h0,         0, 0,  32'h0,         1, 1, 1, 2, 32'hA2,       32'h1004);
    add(1, 0, 0,  32'h0,         0, 0,  32'h0,         1, 1, 1, 12, 32'hB2,      32'h1000);
    add(1, 0, 0,  32'h0,         0, 0,  32'h0,         1, 1, 0, 12, 32'hB2,      32'h0);

    repeat (2) @(posedge clk);

    foreach (vecs[k]) begin
      @(negedge clk);
      reset         = vecs[k].rst;
      bus.alu_valid = vecs[k].av;
      bus.alu_rd    = vecs[k].ard;
      bus.alu_data  = vecs[k].adat;
      bus.ld_valid  = vecs[k].lv;
      bus.ld_rd     = vecs[k].lrd;
      bus.ld_data   = vecs[k].ldat;
      #1;
      check("alu_ready", k, 32'(bus.alu_ready), 32'(vecs[k].e_ar));
      check("ld_ready",  k, 32'(bus.ld_ready),  32'(vecs[k].e_lr));
      check("RegW",      k, 32'(bus.RegW),      32'(vecs[k].e_regw));
      check("A3",        k, 32'(bus.A3),        32'(vecs[k].e_a3));
      check("Result",    k, bus.Result,         vecs[k].e_res);
      check("busy",      k, bus.busy,           vecs[k].e_busy);
    end

    // Streaming: both sources valid every cycle, ALU rd 1..4, LD rd 11..14.
    @(negedge clk);
    reset = 1'b0;
    bus.alu_valid = 1'b0;
    bus.ld_valid  = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    ai = 0; li = 0; nw = 0; first_cyc = -1; last_cyc = -1;
    alu_stall = 1'b0; ld_stall = 1'b0;
    for (int cyc = 0; cyc < 40 && nw < 8; cyc++) begin
      bus.alu_valid = (ai < 4);
      bus.alu_rd    = 5'(1 + ai);
      bus.alu_data  = 32'hA000_0000 | 32'(ai);
      bus.ld_valid  = (li < 4);
      bus.ld_rd     = 5'(11 + li);
      bus.ld_data   = 32'hB000_0000 | 32'(li);
      #1;
      if (bus.RegW) begin
        got_rd[nw]   = bus.A3;
        got_data[nw] = bus.Result;
        if (first_cyc < 0) first_cyc = cyc;
        last_cyc = cyc;
        nw++;
      end
      if (bus.alu_valid && !bus.alu_ready) alu_stall = 1'b1;
      if (bus.ld_valid  && !bus.ld_ready)  ld_stall  = 1'b1;
      if (bus.alu_valid && bus.alu_ready)  ai++;
      if (bus.ld_valid  && bus.ld_ready)   li++;
      @(negedge clk);
    end
    bus.alu_valid = 1'b0;
    bus.ld_valid  = 1'b0;

    check("stream_writes", 0, 32'(nw), 32'd8);
    for (int k = 0; k < nw; k++) begin
      if (k % 2 == 0) begin
        check("stream_rd",   k, 32'(got_rd[k]), 32'(1 + k / 2));
        check("stream_data", k, got_data[k],    32'hA000_0000 | 32'(k / 2));
      end else begin
        check("stream_rd",   k, 32'(got_rd[k]), 32'(11 + k / 2));
        check("stream_data", k, got_data[k],    32'hB000_0000 | 32'(k / 2));
      end
    end
    check("stream_span",      0, 32'(last_cyc - first_cyc), 32'd7);
    check("stream_alu_stall", 0, 32'(alu_stall), 32'd1);
    check("stream_ld_stall",  0, 32'(ld_stall),  32'd1);

    #1;
    check("stream_idle_RegW", 0, 32'(bus.RegW), 32'd0);
    check("stream_idle_busy", 0, bus.busy, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
